// File: rtl/proj_seg_reader.sv
// Scans a combinational-read projection RAM once per start request and emits
// one (start,end) coordinate pair per run of non-zero entries over valid/ready.
module proj_seg_reader #(
  parameter int WIDTH   = 1,
  parameter int DEPTH   = 800,
  parameter int DEPBIT  = 10,
  parameter int MAX_SEG = 8,
  parameter int SEGBIT  = $clog2(MAX_SEG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DEPBIT-1:0] raddr,
  input  logic [WIDTH-1:0]  rd_dq,
  output logic              seg_valid,
  input  logic              seg_ready,
  output logic [DEPBIT-1:0] seg_start,
  output logic [DEPBIT-1:0] seg_end,
  output logic [SEGBIT-1:0] seg_idx,
  output logic [SEGBIT-1:0] seg_cnt,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD, S_FINISH} state_t;

  localparam logic [DEPBIT-1:0] LAST_ADDR = DEPBIT'(DEPTH - 1);
  localparam logic [SEGBIT-1:0] SEG_LIMIT = SEGBIT'(MAX_SEG);

  state_t            r_state,     w_state_nx;
  logic [DEPBIT-1:0] r_raddr,     w_raddr_nx;
  logic              r_prev,      w_prev_nx;
  logic [DEPBIT-1:0] r_run_start, w_run_start_nx;
  logic [DEPBIT-1:0] r_seg_start, w_seg_start_nx;
  logic [DEPBIT-1:0] r_seg_end,   w_seg_end_nx;
  logic [SEGBIT-1:0] r_seg_idx,   w_seg_idx_nx;
  logic [SEGBIT-1:0] r_seg_cnt,   w_seg_cnt_nx;
  logic              r_seg_valid, w_seg_valid_nx;
  logic              r_last,      w_last_nx;
  logic              r_overflow,  w_overflow_nx;
  logic              r_busy,      w_busy_nx;
  logic              r_done,      w_done_nx;

  logic              w_cur;
  logic              w_at_end;
  logic              w_fall;
  logic              w_close;
  logic [DEPBIT-1:0] w_close_start;
  logic [DEPBIT-1:0] w_close_end;

  assign w_cur    = |rd_dq;
  assign w_at_end = (r_raddr == LAST_ADDR);
  assign w_fall   = r_prev & ~w_cur;
  assign w_close  = w_fall | (w_cur & w_at_end);
  // A run still open at the last address may be a single entry there,
  // in which case no rising edge was recorded before it.
  assign w_close_start = r_prev ? r_run_start : r_raddr;
  assign w_close_end   = w_fall ? (r_raddr - 1'b1) : LAST_ADDR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_raddr_nx     = r_raddr;
    w_prev_nx      = r_prev;
    w_run_start_nx = r_run_start;
    w_seg_start_nx = r_seg_start;
    w_seg_end_nx   = r_seg_end;
    w_seg_idx_nx   = r_seg_idx;
    w_seg_cnt_nx   = r_seg_cnt;
    w_seg_valid_nx = r_seg_valid;
    w_last_nx      = r_last;
    w_overflow_nx  = r_overflow;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_raddr_nx    = '0;
          w_prev_nx     = 1'b0;
          w_seg_cnt_nx  = '0;
          w_overflow_nx = 1'b0;
          w_busy_nx     = 1'b1;
          w_state_nx    = S_SCAN;
        end
      end
      S_SCAN: begin
        w_prev_nx = w_cur;
        if (!w_at_end) begin
          w_raddr_nx = r_raddr + 1'b1;
        end
        if (!r_prev && w_cur) begin
          w_run_start_nx = r_raddr;
        end
        if (w_close && (r_seg_cnt < SEG_LIMIT)) begin
          w_seg_start_nx = w_close_start;
          w_seg_end_nx   = w_close_end;
          w_seg_idx_nx   = r_seg_cnt;
          w_seg_valid_nx = 1'b1;
          w_last_nx      = w_at_end;
          w_state_nx     = S_HOLD;
        end else begin
          if (w_close) begin
            w_overflow_nx = 1'b1;
          end
          if (w_at_end) begin
            w_state_nx = S_FINISH;
          end
        end
      end
      S_HOLD: begin
        if (seg_ready) begin
          w_seg_valid_nx = 1'b0;
          w_seg_cnt_nx   = r_seg_cnt + 1'b1;
          w_state_nx     = r_last ? S_FINISH : S_SCAN;
        end
      end
      S_FINISH: begin
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr     <= '0;
      r_prev      <= 1'b0;
      r_run_start <= '0;
      r_seg_start <= '0;
      r_seg_end   <= '0;
      r_seg_idx   <= '0;
      r_seg_cnt   <= '0;
      r_seg_valid <= 1'b0;
      r_last      <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_raddr     <= w_raddr_nx;
      r_prev      <= w_prev_nx;
      r_run_start <= w_run_start_nx;
      r_seg_start <= w_seg_start_nx;
      r_seg_end   <= w_seg_end_nx;
      r_seg_idx   <= w_seg_idx_nx;
      r_seg_cnt   <= w_seg_cnt_nx;
      r_seg_valid <= w_seg_valid_nx;
      r_last      <= w_last_nx;
      r_overflow  <= w_overflow_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
    end
  end

  assign raddr     = r_raddr;
  assign seg_valid = r_seg_valid;
  assign seg_start = r_seg_start;
  assign seg_end   = r_seg_end;
  assign seg_idx   = r_seg_idx;
  assign seg_cnt   = r_seg_cnt;
  assign overflow  = r_overflow;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_proj_seg_reader.sv
// Directed bench for proj_seg_reader: default instance plus a MAX_SEG=4
// instance for the overflow case, both reading one behavioural RAM.
module tb_proj_seg_reader;

  logic       clk;
  logic       rst_n;
  logic       mem [0:1023];

  logic       start_a, ready_a, rd_a, valid_a, ovf_a, busy_a, done_a;
  logic [9:0] raddr_a, s_a, e_a;
  logic [3:0] idx_a, cnt_a;

  logic       start4, ready4, rd4, valid4, ovf4, busy4, done4;
  logic [9:0] raddr4, s4, e4;
  logic [2:0] idx4, cnt4;

  int         n_checks;
  int         n_errors;
  int         n_seg, n_done, cyc, max_addr;
  logic [9:0] seg_s [0:15];
  logic [9:0] seg_e [0:15];
  logic [3:0] seg_i [0:15];

  assign rd_a = mem[raddr_a];
  assign rd4  = mem[raddr4];

  proj_seg_reader #(.WIDTH(1), .DEPTH(800), .DEPBIT(10), .MAX_SEG(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .raddr(raddr_a), .rd_dq(rd_a),
    .seg_valid(valid_a), .seg_ready(ready_a), .seg_start(s_a), .seg_end(e_a),
    .seg_idx(idx_a), .seg_cnt(cnt_a), .overflow(ovf_a), .busy(busy_a), .done(done_a)
  );

  proj_seg_reader #(.WIDTH(1), .DEPTH(800), .DEPBIT(10), .MAX_SEG(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .raddr(raddr4), .rd_dq(rd4),
    .seg_valid(valid4), .seg_ready(ready4), .seg_start(s4), .seg_end(e4),
    .seg_idx(idx4), .seg_cnt(cnt4), .overflow(ovf4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
  endtask

  task automatic set_run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) mem[i] = 1'b1;
  endtask

  // cyc = cycles from the edge sampling start to the edge raising done
  task automatic run_scan(input bit sel, input int stall, input bit repulse);
    int         stall_left;
    bit         held;
    logic [9:0] h_addr, h_s, h_e;
    logic [3:0] h_i;
    logic       v, d;
    n_seg = 0; n_done = 0; max_addr = 0; cyc = -1;
    stall_left = stall; held = 1'b0;
    h_addr = '0; h_s = '0; h_e = '0; h_i = '0;
    if (sel) start4 = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start_a = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (repulse && k == 10) start_a = 1'b1;
      if (k == 11) start_a = 1'b0;
      if (int'(sel ? raddr4 : raddr_a) > max_addr) max_addr = int'(sel ? raddr4 : raddr_a);
      v = sel ? valid4 : valid_a;
      d = sel ? done4 : done_a;
      if (d) begin
        n_done++;
        cyc = k;
        break;
      end
      if (v && stall_left > 0) begin
        if (!held) begin
          h_addr = raddr_a; h_s = s_a; h_e = e_a; h_i = idx_a; held = 1'b1;
        end else begin
          check("hold_raddr", raddr_a, h_addr);
          check("hold_start", s_a, h_s);
          check("hold_end", e_a, h_e);
          check("hold_idx", idx_a, h_i);
        end
        ready_a = 1'b0;
        stall_left--;
      end else begin
        if (v && n_seg < 16) begin
          seg_s[n_seg] = sel ? s4 : s_a;
          seg_e[n_seg] = sel ? e4 : e_a;
          seg_i[n_seg] = sel ? {1'b0, idx4} : idx_a;
          n_seg++;
        end
        if (sel) ready4 = 1'b1; else ready_a = 1'b1;
      end
      @(negedge clk);
    end
    ready_a = 1'b1; ready4 = 1'b1;
    if (cyc < 0) check("scan_timeout", 0, 1);
    @(negedge clk);
    check("done_pulse_len", sel ? done4 : done_a, 0);
    check("busy_after", sel ? busy4 : busy_a, 0);
  endtask

  task automatic check_test1_result(input int extra);
    check("t1_nseg", n_seg, 2);
    check("t1_s0", seg_s[0], 10);
    check("t1_e0", seg_e[0], 19);
    check("t1_i0", seg_i[0], 0);
    check("t1_s1", seg_s[1], 50);
    check("t1_e1", seg_e[1], 50);
    check("t1_i1", seg_i[1], 1);
    check("t1_cnt", cnt_a, 2);
    check("t1_ovf", ovf_a, 0);
    check("t1_ndone", n_done, 1);
    check("t1_cyc", cyc, 803 + extra);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start_a = 1'b0; start4 = 1'b0; ready_a = 1'b1; ready4 = 1'b1;
    clear_mem();
    #1;
    check("rst_raddr", raddr_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_ovf", ovf_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two runs, no backpressure
    set_run(10, 19); set_run(50, 50);
    run_scan(1'b0, 0, 1'b0);
    check_test1_result(0);

    // 2: runs at both ends of the address space
    clear_mem(); set_run(0, 2); set_run(790, 799);
    run_scan(1'b0, 0, 1'b0);
    check("t2_nseg", n_seg, 2);
    check("t2_s0", seg_s[0], 0);
    check("t2_e0", seg_e[0], 2);
    check("t2_s1", seg_s[1], 790);
    check("t2_e1", seg_e[1], 799);
    check("t2_i1", seg_i[1], 1);
    check("t2_maxaddr", max_addr, 799);
    check("t2_raddr_end", raddr_a, 799);
    check("t2_cyc", cyc, 803);

    // 3: empty RAM
    clear_mem();
    run_scan(1'b0, 0, 1'b0);
    check("t3_nseg", n_seg, 0);
    check("t3_cyc", cyc, 801);
    check("t3_cnt", cnt_a, 0);
    check("t3_ovf", ovf_a, 0);

    // 4: ten single-entry runs against MAX_SEG=4
    for (int i = 0; i < 10; i++) mem[100 + 2 * i] = 1'b1;
    run_scan(1'b1, 0, 1'b0);
    check("t4_nseg", n_seg, 4);
    check("t4_s0", seg_s[0], 100);
    check("t4_e3", seg_e[3], 106);
    check("t4_i3", seg_i[3], 3);
    check("t4_ovf", ovf4, 1);
    check("t4_cnt", cnt4, 4);
    check("t4_cyc", cyc, 805);

    // 5: first segment held 5 cycles
    clear_mem(); set_run(10, 19); set_run(50, 50);
    run_scan(1'b0, 5, 1'b0);
    check_test1_result(5);

    // 6: asynchronous abort mid-scan, then a clean rescan with a stray start
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 2000 && raddr_a != 10'd300; k++) @(negedge clk);
    check("t6_reach300", raddr_a, 300);
    #2 rst_n = 1'b0;
    #1;
    check("t6_raddr", raddr_a, 0);
    check("t6_busy", busy_a, 0);
    check("t6_valid", valid_a, 0);
    check("t6_s", s_a, 0);
    check("t6_cnt", cnt_a, 0);
    @(negedge clk);
    check("t6_nodone", done_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(1'b0, 0, 1'b1);
    check_test1_result(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
